ptr_reg_bank: RTL and testbench
===============================

PTR_REG_BANK -- requirements
Module: ptr_reg_bank

Interface
REQ-001 SHALL have parameter NUM_PTRS, default 3, number of index pointers (X, Y, SP generalised); range 1..8.
REQ-002 SHALL have parameter DATA_W, default 4, nibble/bus width.
REQ-003 SHALL have parameter PTR_W, default 12, pointer width; multiple of DATA_W.
REQ-004 SHALL have parameter WRAP_W, default 8, width of the low pointer field that increments and decrements; WRAP_W <= PTR_W.
REQ-005 SHALL have parameter SP_RESET, default 0, reset value of pointer NUM_PTRS-1; all other pointers reset to 0.
REQ-006 SHALL use clock clk and reset reset_n, synchronous, active-low.
REQ-007 SHALL have ports:
 clk  in  1  clock
 reset_n  in  1  synchronous active-low reset
 fetch  in  1  microcode fetch-phase strobe
 write  in  1  microcode write-phase strobe; never high together with fetch
 nib_we  in  1  nibble write request, acted on only with write
 nib_sel  in  3  target pointer index
 nib_pos  in  3  nibble slot, 0 = LSB nibble
 nib_data  in  DATA_W  nibble value
 inc_en  in  1  post-modify request, acted on only with write
 inc_sel  in  3  pointer to modify
 inc_dir  in  1  0 = +1, 1 = -1
 mem_req  in  1  indirect write request, acted on only with fetch
 mem_sel  in  3  address pointer index
 mem_pre_dec  in  1  address = pointer with low field minus 1
 mem_data  in  DATA_W  data to write
 mem_ack  in  1  memory accepted write
 wrap_clr  in  NUM_PTRS  clear sticky wrap flags
 ptrs  out  NUM_PTRS*PTR_W  all pointers, pointer i at [i*PTR_W +: PTR_W]
 mem_write_en  out  1  write request to memory
 mem_addr  out  PTR_W  write address
 mem_write_data  out  DATA_W  write data
 mem_busy  out  1  write outstanding
 wrap_flag  out  NUM_PTRS  sticky low-field wrap per pointer
 req_err  out  1  one-cycle pulse, request dropped

Function
REQ-008 SHALL, on clock edge with write and nib_we, set ptr[nib_sel][nib_pos*DATA_W +: DATA_W] to nib_data; nib_sel >= NUM_PTRS or nib_pos >= PTR_W/DATA_W: no write, req_err pulses.
REQ-009 SHALL, on edge with write and inc_en, replace low WRAP_W bits of ptr[inc_sel] with that field +1 or -1 modulo 2^WRAP_W; upper PTR_W-WRAP_W bits unchanged; inc_sel out of range: no change, req_err.
REQ-010 SHALL, when nib and inc target the same pointer on one edge, apply the nibble write first and the modify to the written value.
REQ-011 SHALL set wrap_flag[i] when a modify carries out of (0xFF->0x00) or borrows into (0x00->0xFF) the low field; wrap_clr[i] clears it; set wins over a simultaneous clear.
REQ-012 SHALL, on edge with fetch, mem_req and mem_busy low, capture mem_addr = ptr[mem_sel] (low field -1 modulo 2^WRAP_W if mem_pre_dec, upper bits unchanged), mem_write_data = mem_data, and assert mem_write_en and mem_busy from the next cycle.
REQ-013 SHALL use pointer values from before any same-edge update for the capture in REQ-012.
REQ-014 SHALL hold mem_write_en, mem_addr and mem_write_data stable while busy; on the edge where mem_ack is high with mem_write_en, deassert mem_write_en and mem_busy next cycle.
REQ-015 SHALL ignore mem_ack while idle.
REQ-016 SHALL drop a fetch with mem_req while mem_busy is high, or with mem_sel out of range, pulsing req_err; the outstanding write is unaffected.
REQ-017 SHALL expose ptrs directly from registers, no combinational path from inputs.

Reset
REQ-018 SHALL, on edge with reset_n low, set all pointers to 0 except pointer NUM_PTRS-1 = SP_RESET, and set wrap_flag, mem_write_en, mem_busy, req_err, mem_addr, mem_write_data to 0; this aborts an outstanding write and ignores all other inputs that edge.

Verification
REQ-019 Defaults, ptr1 = 0x3FF, write+inc_en sel 1 dir 0 -> ptr1 = 0x300, wrap_flag[1] = 1.
REQ-020 ptr2 = 0x000, write, nib_we sel 2 pos 0 data 0x5, inc_en sel 2 dir 1 -> ptr2 = 0x0004, no wrap.
REQ-021 ptr0 = 0x120, fetch, mem_req sel 0 pre_dec, data 0xA -> next cycle mem_write_en = 1, mem_addr = 0x11F, data 0xA; mem_ack after 3 cycles -> mem_write_en low the cycle after.
REQ-022 Second fetch+mem_req while busy -> req_err one cycle, mem_addr unchanged.
REQ-023 nib_pos = 3 with PTR_W = 12 -> no change, req_err pulse.
REQ-024 reset_n low while mem_busy -> next cycle mem_write_en = 0, ptr2 = SP_RESET, others 0.

Source files
------------

// File: rtl/ptr_reg_bank.sv
// Bank of index pointers with nibble-wise loading, low-field post-modify with sticky
// wrap flags, and a single-outstanding indirect memory write addressed by a pointer.
module ptr_reg_bank #(
  parameter int               NUM_PTRS = 3,
  parameter int               DATA_W   = 4,
  parameter int               PTR_W    = 12,
  parameter int               WRAP_W   = 8,
  parameter logic [PTR_W-1:0] SP_RESET = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      fetch,
  input  logic                      write,
  input  logic                      nib_we,
  input  logic [2:0]                nib_sel,
  input  logic [2:0]                nib_pos,
  input  logic [DATA_W-1:0]         nib_data,
  input  logic                      inc_en,
  input  logic [2:0]                inc_sel,
  input  logic                      inc_dir,
  input  logic                      mem_req,
  input  logic [2:0]                mem_sel,
  input  logic                      mem_pre_dec,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      mem_ack,
  input  logic [NUM_PTRS-1:0]       wrap_clr,
  output logic [NUM_PTRS*PTR_W-1:0] ptrs,
  output logic                      mem_write_en,
  output logic [PTR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  output logic                      mem_busy,
  output logic [NUM_PTRS-1:0]       wrap_flag,
  output logic                      req_err
);

  localparam int NIBS = PTR_W / DATA_W;

  logic [PTR_W-1:0]    ptr_q [NUM_PTRS];
  logic [PTR_W-1:0]    ptr_d [NUM_PTRS];
  logic [NUM_PTRS-1:0] wrap_q, wrap_d, wrap_set;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  logic              nib_ok, inc_ok, mem_ok;
  logic [PTR_W-1:0]  cur_ptr, sel_ptr;
  logic [WRAP_W-1:0] low_fld;

  assign nib_ok = (32'(nib_sel) < NUM_PTRS) && (32'(nib_pos) < NIBS);
  assign inc_ok = 32'(inc_sel) < NUM_PTRS;
  assign mem_ok = 32'(mem_sel) < NUM_PTRS;

  // Nibble load lands first, then the post-modify operates on the loaded value.
  always_comb begin
    wrap_set = '0;
    cur_ptr  = '0;
    low_fld  = '0;
    for (int i = 0; i < NUM_PTRS; i++) begin
      cur_ptr = ptr_q[i];
      if (write && nib_we && nib_ok && (32'(nib_sel) == i)) begin
        for (int k = 0; k < NIBS; k++) begin
          if (32'(nib_pos) == k) cur_ptr[k*DATA_W +: DATA_W] = nib_data;
        end
      end
      if (write && inc_en && inc_ok && (32'(inc_sel) == i)) begin
        low_fld = cur_ptr[WRAP_W-1:0];
        if (inc_dir) begin
          wrap_set[i] = (low_fld == '0);
          low_fld     = low_fld - WRAP_W'(1);
        end else begin
          wrap_set[i] = &low_fld;
          low_fld     = low_fld + WRAP_W'(1);
        end
        cur_ptr[WRAP_W-1:0] = low_fld;
      end
      ptr_d[i] = cur_ptr;
    end
  end

  assign wrap_d = wrap_set | (wrap_q & ~wrap_clr);

  // Address capture always sees the pointer value from before this edge's update.
  always_comb begin
    sel_ptr = '0;
    for (int i = 0; i < NUM_PTRS; i++) begin
      if (32'(mem_sel) == i) sel_ptr = ptr_q[i];
    end
    busy_d  = busy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (busy_q) begin
      if (mem_ack) busy_d = 1'b0;
    end else if (fetch && mem_req && mem_ok) begin
      busy_d  = 1'b1;
      addr_d  = sel_ptr;
      if (mem_pre_dec) addr_d[WRAP_W-1:0] = sel_ptr[WRAP_W-1:0] - WRAP_W'(1);
      wdata_d = mem_data;
    end
    err_d = (write && nib_we && !nib_ok)
          | (write && inc_en && !inc_ok)
          | (fetch && mem_req && (busy_q || !mem_ok));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PTRS; i++) begin
        ptr_q[i] <= (i == NUM_PTRS - 1) ? SP_RESET : '0;
      end
      wrap_q  <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PTRS; gi++) begin : g_ptr_out
      assign ptrs[gi*PTR_W +: PTR_W] = ptr_q[gi];
    end
  endgenerate

  assign mem_write_en   = busy_q;
  assign mem_busy       = busy_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign wrap_flag      = wrap_q;
  assign req_err        = err_q;

endmodule

// File: tb/tb_ptr_reg_bank.sv
// Directed bench for ptr_reg_bank: expectations are queued as each step is driven
// and popped against the outputs sampled 1 time unit after the following clock edge.
module tb_ptr_reg_bank;

  localparam int NP = 3;
  localparam int DW = 4;
  localparam int PW = 12;
  localparam logic [PW-1:0] SP = 12'h7F0;

  logic          clk = 1'b0;
  logic          reset_n, fetch, write, nib_we, inc_en, inc_dir;
  logic          mem_req, mem_pre_dec, mem_ack;
  logic [2:0]    nib_sel, nib_pos, inc_sel, mem_sel;
  logic [DW-1:0] nib_data, mem_data;
  logic [NP-1:0] wrap_clr;
  logic [NP*PW-1:0] ptrs;
  logic          mem_write_en, mem_busy, req_err;
  logic [PW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic [NP-1:0] wrap_flag;

  ptr_reg_bank #(.NUM_PTRS(NP), .DATA_W(DW), .PTR_W(PW), .WRAP_W(8), .SP_RESET(SP)) dut (
    .clk(clk), .reset_n(reset_n), .fetch(fetch), .write(write),
    .nib_we(nib_we), .nib_sel(nib_sel), .nib_pos(nib_pos), .nib_data(nib_data),
    .inc_en(inc_en), .inc_sel(inc_sel), .inc_dir(inc_dir),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_pre_dec(mem_pre_dec),
    .mem_data(mem_data), .mem_ack(mem_ack), .wrap_clr(wrap_clr),
    .ptrs(ptrs), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_busy(mem_busy),
    .wrap_flag(wrap_flag), .req_err(req_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic push(input string tag, input logic [63:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) passed++;
      else $error("FAIL %s: observed %0h required %0h", x.tag, obs, x.exp);
      $display("check %-12s observed %0h required %0h", x.tag, obs, x.exp);
    end
  endtask

  task automatic idle();
    reset_n = 1'b1; fetch = 1'b0; write = 1'b0; nib_we = 1'b0; inc_en = 1'b0;
    inc_dir = 1'b0; mem_req = 1'b0; mem_pre_dec = 1'b0; mem_ack = 1'b0;
    nib_sel = '0; nib_pos = '0; inc_sel = '0; mem_sel = '0;
    nib_data = '0; mem_data = '0; wrap_clr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ptr(input logic [2:0] sel, input logic [PW-1:0] v);
    for (int k = 0; k < PW / DW; k++) begin
      idle();
      write = 1'b1; nib_we = 1'b1; nib_sel = sel; nib_pos = 3'(k);
      nib_data = v[k*DW +: DW];
      tick();
    end
    idle();
  endtask

  function automatic logic [63:0] pk(input logic [PW-1:0] p2, p1, p0);
    return 64'({p2, p1, p0});
  endfunction

  initial begin
    idle();
    reset_n = 1'b0;
    push("rst_ptrs", pk(SP, 0, 0)); push("rst_we", 0); push("rst_busy", 0);
    push("rst_wrap", 0); push("rst_err", 0);
    tick();
    chk(64'(ptrs)); chk(64'(mem_write_en)); chk(64'(mem_busy)); chk(64'(wrap_flag)); chk(64'(req_err));
    idle();

    // increment carry out of the low field keeps the upper nibble
    set_ptr(3'd1, 12'h3FF);
    write = 1'b1; inc_en = 1'b1; inc_sel = 3'd1; inc_dir = 1'b0;
    push("inc_wrap", pk(SP, 12'h300, 0)); push("wrap_set", 3'b010);
    tick(); chk(64'(ptrs)); chk(64'(wrap_flag));
    idle(); wrap_clr = 3'b010;
    push("wrap_clr", 3'b000);
    tick(); chk(64'(wrap_flag));

    // borrow with a simultaneous clear: set wins
    idle(); write = 1'b1; inc_en = 1'b1; inc_sel = 3'd1; inc_dir = 1'b1; wrap_clr = 3'b010;
    push("dec_borrow", pk(SP, 12'h3FF, 0)); push("set_wins", 3'b010);
    tick(); chk(64'(ptrs)); chk(64'(wrap_flag));
    idle(); wrap_clr = 3'b111; tick(); idle();

    // nibble write then decrement on the same pointer and edge
    set_ptr(3'd2, 12'h000);
    write = 1'b1; nib_we = 1'b1; nib_sel = 3'd2; nib_pos = 3'd0; nib_data = 4'h5;
    inc_en = 1'b1; inc_sel = 3'd2; inc_dir = 1'b1;
    push("nib_then_dec", pk(12'h004, 12'h3FF, 0)); push("no_wrap", 3'b000);
    tick(); chk(64'(ptrs)); chk(64'(wrap_flag));

    // out-of-range nibble slot and pointer index
    idle(); write = 1'b1; nib_we = 1'b1; nib_sel = 3'd0; nib_pos = 3'd3; nib_data = 4'hF;
    push("bad_pos_ptrs", pk(12'h004, 12'h3FF, 0)); push("bad_pos_err", 1);
    tick(); chk(64'(ptrs)); chk(64'(req_err));
    idle(); push("err_pulse", 0);
    tick(); chk(64'(req_err));
    write = 1'b1; inc_en = 1'b1; inc_sel = 3'd3;
    push("bad_inc_ptrs", pk(12'h004, 12'h3FF, 0)); push("bad_inc_err", 1);
    tick(); chk(64'(ptrs)); chk(64'(req_err));
    idle();

    // indirect write with pre-decrement, busy drop, and ack
    set_ptr(3'd0, 12'h120);
    fetch = 1'b1; mem_req = 1'b1; mem_sel = 3'd0; mem_pre_dec = 1'b1; mem_data = 4'hA;
    push("mw_en", 1); push("mw_addr", 12'h11F); push("mw_data", 4'hA); push("mw_busy", 1);
    tick(); chk(64'(mem_write_en)); chk(64'(mem_addr)); chk(64'(mem_write_data)); chk(64'(mem_busy));
    idle(); push("hold_en", 1); push("hold_addr", 12'h11F);
    tick(); chk(64'(mem_write_en)); chk(64'(mem_addr));
    fetch = 1'b1; mem_req = 1'b1; mem_sel = 3'd1; mem_data = 4'h3;
    push("busy_err", 1); push("busy_addr", 12'h11F); push("busy_data", 4'hA);
    tick(); chk(64'(req_err)); chk(64'(mem_addr)); chk(64'(mem_write_data));
    idle(); mem_ack = 1'b1;
    push("ack_en", 0); push("ack_busy", 0);
    tick(); chk(64'(mem_write_en)); chk(64'(mem_busy));
    push("idle_ack", 0);
    tick(); chk(64'(mem_write_en));
    idle();

    // pre-decrement borrow stays within the low field
    set_ptr(3'd0, 12'h100);
    fetch = 1'b1; mem_req = 1'b1; mem_sel = 3'd0; mem_pre_dec = 1'b1; mem_data = 4'h6;
    push("pd_addr", 12'h1FF); push("pd_ptrs", pk(12'h004, 12'h3FF, 12'h100));
    tick(); chk(64'(mem_addr)); chk(64'(ptrs));
    idle(); mem_ack = 1'b1; tick(); idle();

    fetch = 1'b1; mem_req = 1'b1; mem_sel = 3'd3;
    push("bad_sel_err", 1); push("bad_sel_busy", 0);
    tick(); chk(64'(req_err)); chk(64'(mem_busy));

    // reset aborts an outstanding write
    idle(); fetch = 1'b1; mem_req = 1'b1; mem_sel = 3'd2; mem_data = 4'h9;
    push("plain_addr", 12'h004); push("plain_busy", 1);
    tick(); chk(64'(mem_addr)); chk(64'(mem_busy));
    idle(); reset_n = 1'b0; mem_ack = 1'b1;
    push("abort_en", 0); push("abort_ptrs", pk(SP, 0, 0)); push("abort_addr", 0);
    tick(); chk(64'(mem_write_en)); chk(64'(ptrs)); chk(64'(mem_addr));
    idle();

    if (sb.size() != 0) begin
      checks++;
      $error("FAIL scoreboard_left: observed %0d required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
